pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32I core; it is the producer of the enable and flush inputs consumed by every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and of the PC-update enable.
- Detects load-use hazards, taken-branch redirects, instruction-fetch wait and data-memory wait.
- Runs a data-memory wait FSM with a timeout, and keeps stall and flush event counters.

Parameters:
- XLEN, 32, width of the event counters.
- TIMEOUT_CYC, 16, max consecutive dmem wait cycles before abort; legal range 2..255.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump (redirect).
- imem_ready  in  1  instruction fetch data valid this cycle.
- mem_dmem_req  in  1  MEM stage issues a data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register update enable.
- en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  pipe-register enables.
- flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  pipe-register flushes.
- mem_err  out  1  one-cycle pulse on dmem timeout.
- stall_cnt  out  XLEN  count of cycles with any stall.
- flush_cnt  out  XLEN  count of branch flush events.

Behaviour:
- Reset (rst=1 at a clock edge): FSM goes to IDLE; wait_cnt, stall_cnt and flush_cnt become 0; mem_err becomes 0.
- While rst=1, all enables are 1 and all flushes are 1, so the pipe registers clear.
- Control outputs are combinational from the inputs and the FSM state, with zero latency. Counters and mem_err are registered.
- Default (no hazard): all enables 1, all flushes 0.
- The conditions below are evaluated in priority order; the first match wins.
  - 1. Timeout: state WAIT, wait_cnt = TIMEOUT_CYC-1 and dmem_ready=0. All enables 1, flush_mem_wb=1, mem_err pulses next cycle, FSM goes to IDLE.
  - 2. Freeze: mem_dmem_req=1 and dmem_ready=0. All enables 0, pc_en=0, all flushes 0. Freeze overrides branch and load-use; EX holds, so ex_branch_taken persists and is acted on after release.
  - 3. Branch: ex_branch_taken=1. flush_if_id=1, flush_id_ex=1, pc_en=1. This overrides load-use and the imem stall, because the ID/IF contents are wrong-path.
  - 4. Load-use: ex_mem_read=1, ex_rd != 0, and either (id_use_rs1 and ex_rd = id_rs1) or (id_use_rs2 and ex_rd = id_rs2). pc_en=0, en_if_id=0, flush_id_ex=1.
  - 5. Fetch wait: imem_ready=0. pc_en=0, flush_if_id=1.
- Dmem FSM, states IDLE and WAIT:
  - IDLE→WAIT when mem_dmem_req and !dmem_ready; wait_cnt is set to 1.
  - WAIT increments wait_cnt each cycle.
  - WAIT→IDLE on dmem_ready, or on timeout.
  - If mem_dmem_req drops while in WAIT, the FSM returns to IDLE with no error.
  - dmem_ready arriving on the timeout cycle counts as a completion: no error.
- Counters:
  - stall_cnt increments on any cycle where rule 2, 4 or 5 is active.
  - flush_cnt increments once per cycle in which rule 3 is active.
  - Both counters wrap modulo 2^XLEN.
- Reset asserted mid-WAIT aborts the wait with no mem_err.

Decomposition:
- Shared core package holds:
  - the dmem FSM state enum (IDLE, WAIT);
  - the REG_X0 constant (5'd0);
  - a packed struct stage_ctrl_t {en, flush} used for per-stage controls.
- One natural sub-module, hazard_detect: a purely combinational load-use comparator. The FSM and counters stay in pipe_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → pc_en=0, en_if_id=0, flush_id_ex=1 for 1 cycle; stall_cnt 0→1.
- x0 load: same as above with ex_rd=0 → no stall, all enables 1.
- Branch with hazard: ex_branch_taken=1 together with a load-use match → flush_if_id=1, flush_id_ex=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- Dmem wait: mem_dmem_req=1, dmem_ready low for 3 cycles → all enables 0 for 3 cycles, resume on the 4th; stall_cnt=3, mem_err never set.
- Timeout: TIMEOUT_CYC=4, dmem_ready held 0 → freeze for 3 cycles, flush_mem_wb=1 on the 4th, mem_err=1 one cycle later; a later dmem_ready-low freeze starts a fresh count.
- Mid-wait reset: rst=1 on the 2nd wait cycle → next cycle FSM is IDLE, counters are 0, mem_err=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit of the 5-stage RV32I core.
package pipe_ctrl_pkg;

    // Data-memory wait FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

    // Register x0 is hard-wired to zero, so a load into it never creates a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Per-stage control pair driven into each inter-stage pipeline register.
    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purely combinational load-use comparator between the EX load and the ID sources.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (ex_rd == id_rs1);
    assign rs2_match = id_use_rs2 && (ex_rd == id_rs2);
    assign load_use  = ex_mem_read && (ex_rd != REG_X0) && (rs1_match || rs2_match);

endmodule : hazard_detect

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stage enables/flushes, dmem wait FSM with timeout,
// and stall/flush event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic            imem_ready,
    input  logic            mem_dmem_req,
    input  logic            dmem_ready,
    output logic            pc_en,
    output logic            en_if_id,
    output logic            en_id_ex,
    output logic            en_ex_mem,
    output logic            en_mem_wb,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            flush_ex_mem,
    output logic            flush_mem_wb,
    output logic            mem_err,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    dmem_state_t state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    stage_ctrl_t if_id, id_ex, ex_mem, mem_wb;
    logic        load_use;
    logic        dmem_stall;
    logic        timeout;
    logic        stall_evt;
    logic        flush_evt;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign dmem_stall = mem_dmem_req && !dmem_ready;

    // Priority-ordered hazard resolution, FSM next-state and wait counter update.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        pc_en      = 1'b1;
        if_id      = '{en: 1'b1, flush: 1'b0};
        id_ex      = '{en: 1'b1, flush: 1'b0};
        ex_mem     = '{en: 1'b1, flush: 1'b0};
        mem_wb     = '{en: 1'b1, flush: 1'b0};
        timeout    = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (rst) begin
            // Clear every pipe register while reset is held.
            if_id.flush  = 1'b1;
            id_ex.flush  = 1'b1;
            ex_mem.flush = 1'b1;
            mem_wb.flush = 1'b1;
        end else if (state_q == WAIT && wait_cnt_q == WAIT_LAST && dmem_stall) begin
            // Abort the access: squash the MEM result and let the pipe move on.
            timeout      = 1'b1;
            mem_wb.flush = 1'b1;
        end else if (dmem_stall) begin
            // Freeze everything; EX holds, so a pending branch is acted on later.
            pc_en      = 1'b0;
            if_id.en   = 1'b0;
            id_ex.en   = 1'b0;
            ex_mem.en  = 1'b0;
            mem_wb.en  = 1'b0;
            stall_evt  = 1'b1;
        end else if (ex_branch_taken) begin
            // IF and ID hold wrong-path instructions.
            if_id.flush = 1'b1;
            id_ex.flush = 1'b1;
            flush_evt   = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID one cycle and inject a bubble into EX.
            pc_en       = 1'b0;
            if_id.en    = 1'b0;
            id_ex.flush = 1'b1;
            stall_evt   = 1'b1;
        end else if (!imem_ready) begin
            // Nothing valid fetched: hold the PC and send a bubble into ID.
            pc_en       = 1'b0;
            if_id.flush = 1'b1;
            stall_evt   = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (dmem_stall) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (!mem_dmem_req || dmem_ready || timeout) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and all state updates use non-blocking assignments.
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Event counters (wrap naturally) and the registered timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            if (stall_evt) stall_cnt <= stall_cnt + XLEN'(1);
            if (flush_evt) flush_cnt <= flush_cnt + XLEN'(1);
            mem_err <= timeout;
        end
    end

    assign en_if_id     = if_id.en;
    assign en_id_ex     = id_ex.en;
    assign en_ex_mem    = ex_mem.en;
    assign en_mem_wb    = mem_wb.en;
    assign flush_if_id  = if_id.flush;
    assign flush_id_ex  = id_ex.flush;
    assign flush_ex_mem = ex_mem.flush;
    assign flush_mem_wb = mem_wb.flush;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vectors with literal expectations
// plus a run-length model of the dmem wait compared on every falling edge.
module tb_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int TOUT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic            imem_ready, mem_dmem_req, dmem_ready;
    logic            pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic            flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic            mem_err;
    logic [XLEN-1:0] stall_cnt, flush_cnt;
    logic [8:0]      ctl;

    int checks = 0;
    int errors = 0;

    // Model state: number of consecutive preceding dmem-wait cycles, plus counters.
    int              wait_len = 0;
    logic [XLEN-1:0] m_stall  = '0;
    logic [XLEN-1:0] m_flush  = '0;
    logic            m_err    = 1'b0;

    pipe_ctrl #(.XLEN(XLEN), .TIMEOUT_CYC(TOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .mem_dmem_req    (mem_dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .en_if_id        (en_if_id),
        .en_id_ex        (en_id_ex),
        .en_ex_mem       (en_ex_mem),
        .en_mem_wb       (en_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem),
        .flush_mem_wb    (flush_mem_wb),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}
    assign ctl = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model by one clock.
    always @(negedge clk) begin
        logic [8:0] exp_ctl;
        logic       lu, dwait, tout_now, frz, br, ld, fw;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        dwait    = mem_dmem_req && !dmem_ready;
        tout_now = !rst && dwait && (wait_len == TOUT - 1);
        frz      = !rst && !tout_now && dwait;
        br       = !rst && !tout_now && !frz && ex_branch_taken;
        ld       = !rst && !tout_now && !frz && !br && lu;
        fw       = !rst && !tout_now && !frz && !br && !ld && !imem_ready;
        if (rst)           exp_ctl = 9'b1_1111_1111;
        else if (tout_now) exp_ctl = 9'b1_1111_0001;
        else if (frz)      exp_ctl = 9'b0_0000_0000;
        else if (br)       exp_ctl = 9'b1_1111_1100;
        else if (ld)       exp_ctl = 9'b0_0111_0100;
        else if (fw)       exp_ctl = 9'b0_1111_1000;
        else               exp_ctl = 9'b1_1111_0000;

        check("model_ctl", 32'(ctl), 32'(exp_ctl));
        check("model_stall_cnt", stall_cnt, m_stall);
        check("model_flush_cnt", flush_cnt, m_flush);
        check("model_mem_err", 32'(mem_err), 32'(m_err));

        if (rst) begin
            wait_len = 0;
            m_stall  = '0;
            m_flush  = '0;
            m_err    = 1'b0;
        end else begin
            m_err    = tout_now;
            wait_len = (dwait && !tout_now) ? wait_len + 1 : 0;
            if (frz || ld || fw) m_stall = m_stall + 1;
            if (br)              m_flush = m_flush + 1;
        end
    end

    task automatic set_default();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        imem_ready = 1'b1; mem_dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_x(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    endtask

    initial begin
        set_default();
        rst = 1'b1;
        @(negedge clk); check("reset_ctl", 32'(ctl), 32'h1FF);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        check("reset_mem_err", 32'(mem_err), 32'd0);
        check("idle_ctl", 32'(ctl), 32'h1F0);

        // Load-use on rs2.
        tick(); load_use_x(5'd5);
        @(negedge clk); check("load_use_ctl", 32'(ctl), 32'h074);
        tick(); set_default();
        @(negedge clk); check("load_use_stall_cnt", stall_cnt, 32'd1);
        check("after_load_use_ctl", 32'(ctl), 32'h1F0);

        // Load into x0 never stalls.
        tick(); load_use_x(5'd0); id_rs2 = 5'd0;
        @(negedge clk); check("x0_load_ctl", 32'(ctl), 32'h1F0);

        // Branch beats a coincident load-use.
        tick(); load_use_x(5'd5); ex_branch_taken = 1'b1;
        @(negedge clk); check("branch_hazard_ctl", 32'(ctl), 32'h1FC);
        tick(); set_default();
        @(negedge clk);
        check("branch_flush_cnt", flush_cnt, 32'd1);
        check("branch_stall_cnt", stall_cnt, 32'd1);

        // Fetch wait.
        tick(); imem_ready = 1'b0;
        @(negedge clk); check("fetch_wait_ctl", 32'(ctl), 32'h0F8);

        // Dmem wait for 3 cycles with a branch held in EX; ready on the timeout cycle.
        for (int i = 0; i < 3; i++) begin
            tick(); set_default(); mem_dmem_req = 1'b1; ex_branch_taken = 1'b1;
            @(negedge clk); check("dmem_freeze_ctl", 32'(ctl), 32'h000);
        end
        tick(); dmem_ready = 1'b1;
        @(negedge clk); check("dmem_release_branch_ctl", 32'(ctl), 32'h1FC);
        tick(); set_default();
        @(negedge clk);
        check("dmem_wait_stall_cnt", stall_cnt, 32'd5);
        check("dmem_wait_flush_cnt", flush_cnt, 32'd2);
        check("dmem_wait_no_err", 32'(mem_err), 32'd0);

        // Timeout: ready held low; afterwards a fresh wait count starts.
        tick(); mem_dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("timeout_freeze_ctl", 32'(ctl), 32'h000);
            tick();
        end
        @(negedge clk);
        check("timeout_ctl", 32'(ctl), 32'h1F1);
        check("timeout_err_not_yet", 32'(mem_err), 32'd0);
        tick();
        @(negedge clk);
        check("timeout_err_pulse", 32'(mem_err), 32'd1);
        check("fresh_freeze_ctl", 32'(ctl), 32'h000);
        tick();
        @(negedge clk); check("timeout_err_one_cycle", 32'(mem_err), 32'd0);
        tick();
        @(negedge clk); check("fresh_freeze3_ctl", 32'(ctl), 32'h000);
        tick(); set_default();
        @(negedge clk); check("timeout_stall_cnt", stall_cnt, 32'd11);

        // Request dropped mid-wait returns to idle without error.
        for (int i = 0; i < 6; i++) begin
            tick(); set_default(); mem_dmem_req = (i != 2);
        end
        tick(); set_default();
        @(negedge clk);
        check("req_drop_stall_cnt", stall_cnt, 32'd16);
        check("req_drop_no_err", 32'(mem_err), 32'd0);

        // Reset on the 2nd wait cycle aborts the wait.
        tick(); mem_dmem_req = 1'b1;
        tick(); rst = 1'b1;
        @(negedge clk); check("midwait_reset_ctl", 32'(ctl), 32'h1FF);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("midwait_stall_cnt", stall_cnt, 32'd0);
        check("midwait_flush_cnt", flush_cnt, 32'd0);
        check("midwait_mem_err", 32'(mem_err), 32'd0);
        tick();
        @(negedge clk); check("midwait_fresh_freeze_ctl", 32'(ctl), 32'h000);
        tick();
        tick(); set_default();
        @(negedge clk); check("midwait_final_stall_cnt", stall_cnt, 32'd3);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_ctrl
